// File: rtl/pe_acc_io.sv
// pe_acc_io: accumulator load/drain sequencer for one row of COLS systolic PEs.
//
// Load path pushes N words of C into every PE (pe_we/pe_c, zero latency from
// ld_valid/ld_data). Drain path requests N accumulated words back from the
// PEs (pe_out_ready, data one cycle later on pe_out_sum) and forwards them on
// the res_* stream through a 2-entry buffer guarded by a credit check.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   ld_valid/ld_ready   C beat handshake, ld_data = one DW word per lane
//   ld_done             one-cycle pulse after the N-th accepted load beat
//   drain_start         starts a drain (IDLE only), drain_busy high meanwhile
//   pe_we, pe_c         PE accumulator write strobe / data
//   pe_wben             PE write-back enable (high during drain)
//   pe_out_ready        per-PE word request, pe_out_sum = registered PE result
//   res_valid/ready     result stream handshake, res_data, res_last = word N-1
module pe_acc_io #(
    parameter int N    = 4,
    parameter int COLS = 4,
    parameter int DW   = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               ld_valid,
    output logic               ld_ready,
    input  logic [COLS*DW-1:0] ld_data,
    output logic               ld_done,
    input  logic               drain_start,
    output logic               drain_busy,
    output logic               pe_we,
    output logic [COLS*DW-1:0] pe_c,
    output logic               pe_wben,
    output logic               pe_out_ready,
    input  logic [COLS*DW-1:0] pe_out_sum,
    output logic               res_valid,
    input  logic               res_ready,
    output logic [COLS*DW-1:0] res_data,
    output logic               res_last
);

    localparam int CW = $clog2(N);
    localparam int IW = CW + 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_DRAIN
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;

    logic [CW-1:0]      r_ld_cnt;
    logic               r_ld_done;
    logic [IW-1:0]      r_issue_cnt;
    logic [IW-1:0]      r_rcv_cnt;
    logic               r_s1;
    logic [1:0]         r_occ;
    logic [COLS*DW-1:0] r_buf0;
    logic [COLS*DW-1:0] r_buf1;
    logic               r_last0;
    logic               r_last1;

    logic               w_ld_acc;
    logic               w_ld_wrap;
    logic               w_pop;
    logic               w_pop_last;
    logic               w_cap_last;
    logic [2:0]         w_credit;

    // drain_start wins over a same-cycle load beat in IDLE
    assign ld_ready  = ((r_state == S_IDLE) && !drain_start) || (r_state == S_LOAD);
    assign w_ld_acc  = ld_valid && ld_ready;
    assign w_ld_wrap = w_ld_acc && (r_ld_cnt == CW'(N - 1));
    assign pe_we     = w_ld_acc;
    assign pe_c      = ld_data;
    assign ld_done   = r_ld_done;

    assign res_valid  = (r_occ != 2'd0);
    assign res_data   = r_buf0;
    assign res_last   = res_valid && r_last0;
    assign w_pop      = res_valid && res_ready;
    assign w_pop_last = w_pop && r_last0;
    assign w_cap_last = (r_rcv_cnt == IW'(N - 1));

    // Words already owed to the buffer after this cycle: stored + in flight - leaving.
    // A new request is only issued if that leaves room for it.
    assign w_credit     = {1'b0, r_occ} + {2'b00, r_s1} - {2'b00, w_pop};
    assign pe_out_ready = (r_state == S_DRAIN) && (r_issue_cnt < IW'(N)) && (w_credit < 3'd2);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        drain_busy  = 1'b0;
        pe_wben     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (drain_start) begin
                    w_state_nxt = S_DRAIN;
                end else if (w_ld_acc) begin
                    w_state_nxt = S_LOAD;
                end
            end
            S_LOAD: begin
                if (w_ld_wrap) begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_DRAIN: begin
                drain_busy = 1'b1;
                pe_wben    = 1'b1;
                if (w_pop_last) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ld_cnt    <= '0;
            r_ld_done   <= 1'b0;
            r_issue_cnt <= '0;
            r_rcv_cnt   <= '0;
            r_s1        <= 1'b0;
        end else begin
            r_ld_done <= w_ld_wrap;
            // N is a power of two, so the natural roll-over is the wrap to 0
            if (w_ld_acc) begin
                r_ld_cnt <= r_ld_cnt + CW'(1);
            end
            r_s1 <= pe_out_ready;
            if (w_pop_last) begin
                r_issue_cnt <= '0;
                r_rcv_cnt   <= '0;
            end else begin
                if (pe_out_ready) begin
                    r_issue_cnt <= r_issue_cnt + IW'(1);
                end
                if (r_s1) begin
                    r_rcv_cnt <= r_rcv_cnt + IW'(1);
                end
            end
        end
    end

    // Two-entry FIFO kept as a shift pair: r_buf0 is always the head
    always_ff @(posedge clk) begin
        if (rst) begin
            r_occ   <= 2'd0;
            r_buf0  <= '0;
            r_buf1  <= '0;
            r_last0 <= 1'b0;
            r_last1 <= 1'b0;
        end else begin
            case ({r_s1, w_pop})
                2'b10: begin
                    if (r_occ == 2'd0) begin
                        r_buf0  <= pe_out_sum;
                        r_last0 <= w_cap_last;
                    end else begin
                        r_buf1  <= pe_out_sum;
                        r_last1 <= w_cap_last;
                    end
                    r_occ <= r_occ + 2'd1;
                end
                2'b01: begin
                    r_buf0  <= r_buf1;
                    r_last0 <= r_last1;
                    r_occ   <= r_occ - 2'd1;
                end
                2'b11: begin
                    if (r_occ == 2'd1) begin
                        r_buf0  <= pe_out_sum;
                        r_last0 <= w_cap_last;
                    end else begin
                        r_buf0  <= r_buf1;
                        r_last0 <= r_last1;
                        r_buf1  <= pe_out_sum;
                        r_last1 <= w_cap_last;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pe_acc_io.sv
// Directed self-checking bench for pe_acc_io with a behavioural PE row model:
// pe_we writes the model's accumulator words in pointer order, pe_out_ready
// reads them back one cycle later on pe_out_sum; rst clears both pointers.
module tb_pe_acc_io;

  localparam int N    = 4;
  localparam int COLS = 4;
  localparam int DW   = 32;
  localparam int PW   = $clog2(N);

  logic               clk;
  logic               rst;
  logic               ld_valid;
  logic               ld_ready;
  logic [COLS*DW-1:0] ld_data;
  logic               ld_done;
  logic               drain_start;
  logic               drain_busy;
  logic               pe_we;
  logic [COLS*DW-1:0] pe_c;
  logic               pe_wben;
  logic               pe_out_ready;
  logic [COLS*DW-1:0] pe_out_sum;
  logic               res_valid;
  logic               res_ready;
  logic [COLS*DW-1:0] res_data;
  logic               res_last;

  int checks = 0;
  int errors = 0;

  pe_acc_io #(.N(N), .COLS(COLS), .DW(DW)) dut (
    .clk          (clk),
    .rst          (rst),
    .ld_valid     (ld_valid),
    .ld_ready     (ld_ready),
    .ld_data      (ld_data),
    .ld_done      (ld_done),
    .drain_start  (drain_start),
    .drain_busy   (drain_busy),
    .pe_we        (pe_we),
    .pe_c         (pe_c),
    .pe_wben      (pe_wben),
    .pe_out_ready (pe_out_ready),
    .pe_out_sum   (pe_out_sum),
    .res_valid    (res_valid),
    .res_ready    (res_ready),
    .res_data     (res_data),
    .res_last     (res_last)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // PE row model
  logic [COLS*DW-1:0] pe_mem [N];
  logic [PW-1:0]      pe_wptr;
  logic [PW-1:0]      pe_rptr;

  always_ff @(posedge clk) begin
    if (rst) begin
      pe_wptr    <= '0;
      pe_rptr    <= '0;
      pe_out_sum <= '0;
    end else begin
      if (pe_we) begin
        pe_mem[pe_wptr] <= pe_c;
        pe_wptr         <= pe_wptr + PW'(1);
      end
      if (pe_out_ready) begin
        pe_out_sum <= pe_mem[pe_rptr];
        pe_rptr    <= pe_rptr + PW'(1);
      end
    end
  end

  task automatic chk(input string tag, input bit ok,
                     input logic [COLS*DW-1:0] obs, input logic [COLS*DW-1:0] exp);
    checks++;
    if (!ok) begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // lane k of word i = base + istep*i + kstep*k
  function automatic logic [COLS*DW-1:0] vec(input logic [DW-1:0] base, input logic [DW-1:0] istep,
                                             input logic [DW-1:0] kstep, input int i);
    logic [COLS*DW-1:0] v;
    v = '0;
    for (int unsigned k = 0; k < COLS; k++) begin
      v[k*DW +: DW] = base + istep * DW'(i) + kstep * DW'(k);
    end
    return v;
  endfunction

  // inputs change 1 time unit after the rising edge, outputs sampled at the falling edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Full drain with res_ready high from cycle 0; returns at cycle 7 (drive point)
  task automatic run_drain(input logic [DW-1:0] base);
    logic [COLS*DW-1:0] expd;
    drain_start = 1'b1;
    res_ready   = 1'b1;
    #4;
    chk("drain_c0_busy", drain_busy === 1'b0, drain_busy, 1'b0);
    chk("drain_c0_req", pe_out_ready === 1'b0, pe_out_ready, 1'b0);
    chk("drain_c0_ldrdy", ld_ready === 1'b0, ld_ready, 1'b0);
    chk("drain_c0_pe_we", pe_we === 1'b0, pe_we, 1'b0);
    step();
    drain_start = 1'b0;
    for (int unsigned c = 1; c <= 6; c++) begin
      #4;
      chk("drain_busy", drain_busy === 1'b1, drain_busy, 1'b1);
      chk("drain_wben", pe_wben === 1'b1, pe_wben, 1'b1);
      chk("drain_req", pe_out_ready === (c <= 4), pe_out_ready, (c <= 4));
      chk("drain_valid", res_valid === (c >= 3), res_valid, (c >= 3));
      chk("drain_last", res_last === (c == 6), res_last, (c == 6));
      chk("drain_pe_we", pe_we === 1'b0, pe_we, 1'b0);
      if (c >= 3) begin
        expd = vec(base, 1, 'h10000, c - 3);
        chk("drain_data", res_data === expd, res_data, expd);
      end
      step();
    end
  endtask

  logic [5:0]         gap_pat;
  logic [3:0]         rr_pat;
  int                 acc_idx;
  int                 we_cnt;
  int                 issued;
  int                 popped;
  logic               hold_prev;
  logic [COLS*DW-1:0] prev_data;
  logic [COLS*DW-1:0] exp_v;

  initial begin
    gap_pat     = 6'b101101;
    rr_pat      = 4'b1001;
    rst         = 1'b1;
    ld_valid    = 1'b0;
    ld_data     = '0;
    drain_start = 1'b0;
    res_ready   = 1'b0;
    step();
    step();
    #4;
    chk("rst_ld_done", ld_done === 1'b0, ld_done, 1'b0);
    chk("rst_busy", drain_busy === 1'b0, drain_busy, 1'b0);
    chk("rst_res_valid", res_valid === 1'b0, res_valid, 1'b0);
    chk("rst_res_data", res_data === '0, res_data, '0);
    step();
    rst     = 1'b0;
    ld_data = vec('h5a5a0000, 0, 1, 0);
    #4;
    chk("idle_pe_we", pe_we === 1'b0, pe_we, 1'b0);
    exp_v = vec('h5a5a0000, 0, 1, 0);
    chk("idle_pe_c", pe_c === exp_v, pe_c, exp_v);
    chk("idle_wben", pe_wben === 1'b0, pe_wben, 1'b0);
    chk("idle_req", pe_out_ready === 1'b0, pe_out_ready, 1'b0);
    chk("idle_res_last", res_last === 1'b0, res_last, 1'b0);
    chk("idle_ld_ready", ld_ready === 1'b1, ld_ready, 1'b1);
    step();

    // Load, no gaps
    for (int unsigned i = 0; i < N; i++) begin
      ld_valid = 1'b1;
      ld_data  = vec(0, 'h100, 1, i);
      #4;
      chk("load_pe_we", pe_we === 1'b1, pe_we, 1'b1);
      exp_v = vec(0, 'h100, 1, i);
      chk("load_pe_c", pe_c === exp_v, pe_c, exp_v);
      chk("load_ld_done_early", ld_done === 1'b0, ld_done, 1'b0);
      step();
    end
    ld_valid = 1'b0;
    #4;
    chk("load_ld_done", ld_done === 1'b1, ld_done, 1'b1);
    chk("load_idle_ready", ld_ready === 1'b1, ld_ready, 1'b1);
    step();
    #4;
    chk("load_ld_done_pulse", ld_done === 1'b0, ld_done, 1'b0);
    step();

    // Load with gaps 1,0,1,1,0,1
    acc_idx = 0;
    we_cnt  = 0;
    for (int unsigned j = 0; j < 6; j++) begin
      ld_valid = gap_pat[j];
      ld_data  = vec('h200, 1, 'h10, acc_idx);
      #4;
      chk("gap_pe_we", pe_we === gap_pat[j], pe_we, gap_pat[j]);
      chk("gap_ld_done_early", ld_done === 1'b0, ld_done, 1'b0);
      if (pe_we) begin
        we_cnt++;
        acc_idx++;
      end
      step();
    end
    ld_valid = 1'b0;
    #4;
    chk("gap_we_count", we_cnt == 4, we_cnt, 4);
    chk("gap_ld_done", ld_done === 1'b1, ld_done, 1'b1);
    step();

    // Load 0xA0..0xA3 then drain with res_ready held high
    for (int unsigned i = 0; i < N; i++) begin
      ld_valid = 1'b1;
      ld_data  = vec('hA0, 1, 'h10000, i);
      step();
    end
    ld_valid = 1'b0;
    step();
    run_drain('hA0);
    #4;
    chk("drain_c7_busy", drain_busy === 1'b0, drain_busy, 1'b0);
    chk("drain_c7_valid", res_valid === 1'b0, res_valid, 1'b0);
    chk("drain_c7_ldrdy", ld_ready === 1'b1, ld_ready, 1'b1);
    step();

    // Drain under res_ready pattern 1,0,0,1
    issued    = 0;
    popped    = 0;
    hold_prev = 1'b0;
    prev_data = '0;
    for (int unsigned c = 0; c < 40; c++) begin
      drain_start = (c == 0);
      res_ready   = rr_pat[c % 4];
      #4;
      if (pe_out_ready) issued++;
      if (hold_prev) begin
        chk("bp_hold_valid", res_valid === 1'b1, res_valid, 1'b1);
        chk("bp_hold_data", res_data === prev_data, res_data, prev_data);
      end
      if (res_valid && res_ready) begin
        exp_v = vec('hA0, 1, 'h10000, popped);
        chk("bp_data", res_data === exp_v, res_data, exp_v);
        chk("bp_last", res_last === (popped == N - 1), res_last, (popped == N - 1));
        popped++;
      end
      chk("bp_credit", (issued - popped) <= 2, issued - popped, 2);
      hold_prev = res_valid && !res_ready;
      prev_data = res_data;
      step();
      if (popped == N) break;
    end
    drain_start = 1'b0;
    res_ready   = 1'b0;
    #4;
    chk("bp_popped", popped == N, popped, N);
    chk("bp_issued", issued == N, issued, N);
    chk("bp_end_busy", drain_busy === 1'b0, drain_busy, 1'b0);
    step();

    // drain_start and ld_valid together: drain wins, load taken afterwards
    ld_valid = 1'b1;
    ld_data  = vec('hB0, 1, 'h10000, 0);
    run_drain('hA0);
    #4;
    chk("coll_c7_busy", drain_busy === 1'b0, drain_busy, 1'b0);
    chk("coll_c7_pe_we", pe_we === 1'b1, pe_we, 1'b1);
    step();
    for (int unsigned i = 1; i < N; i++) begin
      ld_data = vec('hB0, 1, 'h10000, i);
      #4;
      chk("coll_load_pe_we", pe_we === 1'b1, pe_we, 1'b1);
      step();
    end
    ld_valid = 1'b0;
    #4;
    chk("coll_ld_done", ld_done === 1'b1, ld_done, 1'b1);
    step();

    // Reset after the 2nd result word
    drain_start = 1'b1;
    res_ready   = 1'b1;
    step();
    drain_start = 1'b0;
    for (int unsigned c = 1; c <= 4; c++) begin
      #4;
      if (c >= 3) begin
        chk("rstd_valid", res_valid === 1'b1, res_valid, 1'b1);
        exp_v = vec('hB0, 1, 'h10000, c - 3);
        chk("rstd_data", res_data === exp_v, res_data, exp_v);
      end
      step();
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    #4;
    chk("rstd_res_valid", res_valid === 1'b0, res_valid, 1'b0);
    chk("rstd_res_last", res_last === 1'b0, res_last, 1'b0);
    chk("rstd_busy", drain_busy === 1'b0, drain_busy, 1'b0);
    chk("rstd_req", pe_out_ready === 1'b0, pe_out_ready, 1'b0);
    chk("rstd_wben", pe_wben === 1'b0, pe_wben, 1'b0);
    chk("rstd_ld_done", ld_done === 1'b0, ld_done, 1'b0);
    chk("rstd_res_data", res_data === '0, res_data, '0);
    step();
    run_drain('hB0);
    #4;
    chk("rstd_c7_busy", drain_busy === 1'b0, drain_busy, 1'b0);
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
